// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the UART transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MAX_DATA_W = 9;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Data is zero-extended to MAX_DATA_W; the extra zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Handshake and line-side signal bundle of the UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        parity_mode;
    logic              two_stop;
    logic              tx;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_data, tx_valid, parity_mode, two_stop,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid, parity_mode, two_stop,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words (data plus frame config) ahead of the shifter.
module uart_tx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      cnt_r;
    logic [AW:0]      cnt_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (do_push_s && !do_pop_s) begin
            cnt_nxt_s = cnt_r + (AW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            cnt_nxt_s = cnt_r - (AW+1)'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pointers and flags; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == (AW+1)'(DEPTH));
            empty_r <= (cnt_nxt_s == '0);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the shifter.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 27,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk_3125,
    input  logic           rst_n,
    uart_tx_param_if.slave bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state_r,    state_nxt_s;
    logic [BAUD_W-1:0] baud_r,     baud_nxt_s;
    logic [BIT_W-1:0]  bit_r,      bit_nxt_s;
    logic              stop_r,     stop_nxt_s;
    logic              two_stop_r, two_stop_nxt_s;
    logic              par_en_r,   par_en_nxt_s;
    logic              par_bit_r,  par_bit_nxt_s;
    logic [DATA_W-1:0] shift_r,    shift_nxt_s;
    logic              tx_r,       tx_nxt_s;
    logic              busy_r;
    logic              done_r;
    logic              rdy_r,      rdy_nxt_s;
    logic              baud_end_s;
    logic              last_clk_s;
    logic              take_s;
    logic              src_valid_s;
    logic [DATA_W-1:0] src_data_s;
    logic [1:0]        src_mode_s;
    logic              src_two_stop_s;

`ifdef UART_TX_FIFO_EN
    localparam int ENT_W = DATA_W + 3;
    logic [ENT_W-1:0] fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    uart_tx_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_3125),
        .rst_n (rst_n),
        .push  (bus.tx_valid),
        .wdata ({bus.two_stop, bus.parity_mode, bus.tx_data}),
        .pop   (take_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign src_valid_s = !fifo_empty_s;
    assign {src_two_stop_s, src_mode_s, src_data_s} = fifo_rdata_s;
    assign bus.tx_ready = !fifo_full_s;
`else
    assign src_valid_s    = bus.tx_valid;
    assign src_data_s     = bus.tx_data;
    assign src_mode_s     = bus.parity_mode;
    assign src_two_stop_s = bus.two_stop;
    assign bus.tx_ready   = rdy_r;
`endif

    // rdy_r is true exactly in IDLE and in the final clock of the final stop bit.
    assign take_s     = src_valid_s && rdy_r;
    assign baud_end_s = (baud_r == BAUD_LAST);
    assign last_clk_s = (state_r == ST_STOP) && baud_end_s && (stop_r == two_stop_r);

    assign bus.tx      = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;

    // Frame sequencing; a capture overrides the STOP->IDLE exit for back-to-back frames.
    always_comb begin
        state_nxt_s    = state_r;
        bit_nxt_s      = bit_r;
        stop_nxt_s     = stop_r;
        shift_nxt_s    = shift_r;
        two_stop_nxt_s = two_stop_r;
        par_en_nxt_s   = par_en_r;
        par_bit_nxt_s  = par_bit_r;
        tx_nxt_s       = tx_r;
        if (baud_end_s) begin
            baud_nxt_s = '0;
        end else begin
            baud_nxt_s = baud_r + BAUD_W'(1);
        end
        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = '0;
                tx_nxt_s   = 1'b1;
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_nxt_s = ST_DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    tx_nxt_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_end_s && (bit_r == BIT_LAST)) begin
                    if (par_en_r) begin
                        state_nxt_s = ST_PARITY;
                        tx_nxt_s    = par_bit_r;
                    end else begin
                        state_nxt_s = ST_STOP;
                        stop_nxt_s  = 1'b0;
                        tx_nxt_s    = 1'b1;
                    end
                end else if (baud_end_s) begin
                    bit_nxt_s   = bit_r + BIT_W'(1);
                    shift_nxt_s = shift_r >> 1;
                    tx_nxt_s    = shift_r[1];
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_nxt_s = ST_STOP;
                    stop_nxt_s  = 1'b0;
                    tx_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_STOP: begin
                if (baud_end_s && (stop_r == two_stop_r)) begin
                    state_nxt_s = ST_IDLE;
                    tx_nxt_s    = 1'b1;
                end else if (baud_end_s) begin
                    stop_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                baud_nxt_s  = '0;
                tx_nxt_s    = 1'b1;
            end
        endcase
        if (take_s) begin
            state_nxt_s    = ST_START;
            baud_nxt_s     = '0;
            bit_nxt_s      = '0;
            stop_nxt_s     = 1'b0;
            shift_nxt_s    = src_data_s;
            two_stop_nxt_s = src_two_stop_s;
            par_en_nxt_s   = (src_mode_s == PAR_EVEN) || (src_mode_s == PAR_ODD);
            par_bit_nxt_s  = parity_bit(MAX_DATA_W'(src_data_s), src_mode_s);
            tx_nxt_s       = 1'b0;
        end else begin
            two_stop_nxt_s = two_stop_r;
        end
        rdy_nxt_s = (state_nxt_s == ST_IDLE) ||
                    ((state_nxt_s == ST_STOP) && (stop_nxt_s == two_stop_nxt_s) &&
                     (baud_nxt_s == BAUD_LAST));
    end

    // State and output registers; reset abandons any frame and returns the line high.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_r     <= '0;
            bit_r      <= '0;
            stop_r     <= 1'b0;
            two_stop_r <= 1'b0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rdy_r      <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            baud_r     <= baud_nxt_s;
            bit_r      <= bit_nxt_s;
            stop_r     <= stop_nxt_s;
            two_stop_r <= two_stop_nxt_s;
            par_en_r   <= par_en_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= last_clk_s;
            rdy_r      <= rdy_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: randomized and directed frames against a per-cycle line-level model.
module tb_uart_tx_param;
    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FDEPTH = 4;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_W(DW)) bus ();
    uart_tx_param_if #(.DATA_W(5))  bus5 ();

    uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FDEPTH)) dut (
        .clk_3125 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(1), .FIFO_DEPTH(FDEPTH)) dut5 (
        .clk_3125 (clk),
        .rst_n    (rst_n),
        .bus      (bus5)
    );

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  acc_cyc = 0;
    int  busy_cnt = 0;
    int  done_q[$];
    bit  q_lvl[$];          // expected line level per cycle; head is the current cycle
    logic [10:0] fq[$];     // queued words {two_stop, mode, data} when the FIFO is built in
    bit  m_done = 1'b0;
    bit  last_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_frame(input logic [DW-1:0] d, input logic [1:0] pm, input bit ts);
        bit lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) lv.push_back(d[i]);
        if (pm == 2'b01) lv.push_back(($countones(d) % 2) == 1);
        else if (pm == 2'b10) lv.push_back(($countones(d) % 2) == 0);
        lv.push_back(1'b1);
        if (ts) lv.push_back(1'b1);
        foreach (lv[i]) for (int r = 0; r < CPB; r++) q_lvl.push_back(lv[i]);
    endfunction

    function automatic bit model_ready();
`ifdef UART_TX_FIFO_EN
        return fq.size() < FDEPTH;
`else
        return q_lvl.size() <= 1;
`endif
    endfunction

    function automatic void model_edge(input bit rdy);
        bit line_free;
        bit acc;
        line_free = (q_lvl.size() <= 1);
        m_done    = (q_lvl.size() == 1);
        acc       = bus.tx_valid && rdy;
        last_acc  = acc;
        if (acc) acc_cyc = cyc;
        if (q_lvl.size() > 0) void'(q_lvl.pop_front());
`ifdef UART_TX_FIFO_EN
        if (line_free && fq.size() > 0) begin
            logic [10:0] w;
            w = fq.pop_front();
            push_frame(w[7:0], w[9:8], w[10]);
        end
        if (acc) fq.push_back({bus.two_stop, bus.parity_mode, bus.tx_data});
`else
        if (acc) push_frame(bus.tx_data, bus.parity_mode, bus.two_stop);
`endif
    endfunction

    function automatic void model_reset();
        q_lvl.delete();
        fq.delete();
        m_done = 1'b0;
    endfunction

    task automatic cycle();
        bit rdy;
        @(negedge clk);
        rdy = model_ready();
        check_eq("tx", bus.tx, (q_lvl.size() > 0) ? q_lvl[0] : 1'b1);
        check_eq("tx_busy", bus.tx_busy, q_lvl.size() != 0);
        check_eq("tx_done", bus.tx_done, m_done);
        check_eq("tx_ready", bus.tx_ready, rdy);
        if (bus.tx_busy) busy_cnt++;
        if (bus.tx_done) done_q.push_back(cyc);
        @(posedge clk);
        cyc++;
        model_edge(rdy);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] pm, input bit ts);
        bit got;
        got = 1'b0;
        bus.tx_data = d; bus.parity_mode = pm; bus.two_stop = ts; bus.tx_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            cycle();
            got = last_acc;
        end
        bus.tx_valid = 1'b0;
        check_eq("send_accept", got, 1'b1);
    endtask

    initial begin
        bit lvl5[7];
        bit saw_full;
        int nacc;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.parity_mode = 2'b00; bus.two_stop = 1'b0;
        bus5.tx_valid = 1'b0; bus5.tx_data = '0; bus5.parity_mode = 2'b00; bus5.two_stop = 1'b0;

        // reset state
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // single frame 0xA5, even parity, one stop
        done_q.delete();
        send(8'hA5, 2'b01, 1'b0);
        busy_cnt = 0;
        repeat (55) cycle();
        check_eq("t1_done_cnt", done_q.size(), 1);
        check_eq("t1_done_lat", (done_q.size() > 0) ? done_q[0] - acc_cyc : 0, 44 + LAT);
        check_eq("t1_busy_len", busy_cnt, 44);

        // 0x00 odd parity, two stops
        done_q.delete();
        send(8'h00, 2'b10, 1'b1);
        busy_cnt = 0;
        repeat (60) cycle();
        check_eq("t2_done_lat", (done_q.size() > 0) ? done_q[0] - acc_cyc : 0, 48 + LAT);
        check_eq("t2_busy_len", busy_cnt, 48);
        check_eq("t2_tx_idle", bus.tx, 1'b1);

        // back-to-back, no parity, valid held
        done_q.delete();
        nacc = 0;
        bus.tx_data = 8'h55; bus.parity_mode = 2'b00; bus.two_stop = 1'b0; bus.tx_valid = 1'b1;
        for (int i = 0; i < 200 && nacc < 2; i++) begin
            cycle();
            if (last_acc) begin
                nacc++;
                bus.tx_data = 8'h0F;
            end
        end
        bus.tx_valid = 1'b0;
        repeat (100) cycle();
        check_eq("t3_pulses", done_q.size(), 2);
        check_eq("t3_gap", (done_q.size() >= 2) ? done_q[1] - done_q[0] : 0, 40);

        // 5-bit, one clock per bit instance
        lvl5[0] = 1'b0;
        for (int i = 0; i < 5; i++) lvl5[i+1] = 1'b1;
        lvl5[6] = 1'b1;
        bus5.tx_data = 5'h1F; bus5.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus5.tx_valid = 1'b0;
        if (LAT != 0) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq("w5_tx", bus5.tx, lvl5[i]);
            check_eq("w5_busy", bus5.tx_busy, 1'b1);
        end
        @(negedge clk);
        check_eq("w5_done", bus5.tx_done, 1'b1);
        check_eq("w5_idle_tx", bus5.tx, 1'b1);
        check_eq("w5_idle_busy", bus5.tx_busy, 1'b0);
        @(posedge clk); #1;

        // reset in the middle of data bit 3
        send(8'hA5, 2'b01, 1'b0);
        repeat (17) cycle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_tx", bus.tx, 1'b1);
        check_eq("rst_busy", bus.tx_busy, 1'b0);
        check_eq("rst_done", bus.tx_done, 1'b0);
        check_eq("rst_ready", bus.tx_ready, 1'b1);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h3C, 2'b10, 1'b0);
        repeat (55) cycle();

`ifdef UART_TX_FIFO_EN
        // six words pushed back to back fill the FIFO
        saw_full = 1'b0;
        nacc = 0;
        bus.tx_valid = 1'b1; bus.tx_data = 8'($urandom); bus.parity_mode = 2'b01; bus.two_stop = 1'b0;
        for (int i = 0; i < 400 && nacc < 6; i++) begin
            cycle();
            if (!bus.tx_ready) saw_full = 1'b1;
            if (last_acc) begin
                nacc++;
                bus.tx_data = 8'($urandom);
            end
        end
        bus.tx_valid = 1'b0;
        check_eq("fifo_saw_full", saw_full, 1'b1);
        repeat (300) cycle();
        check_eq("fifo_drained", bus.tx_ready && !bus.tx_busy, 1'b1);
`else
        saw_full = 1'b0;
`endif

        // randomized traffic with valid dropping freely
        for (int i = 0; i < 500; i++) begin
            bus.tx_valid    = ($urandom_range(0, 3) != 0);
            bus.tx_data     = 8'($urandom);
            bus.parity_mode = 2'($urandom_range(0, 3));
            bus.two_stop    = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.tx_valid = 1'b0;
        repeat (300) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next generation of the colour-sensor link's serial output stage. Serialises DATA_W-bit words LSB-first with configurable bit period, parity (none/even/odd) and one or two stop bits. Accepts data through a valid/ready handshake with back-to-back frame support. An optional compiled-in FIFO decouples the sensor front end from the line rate.

## Interface
- DATA_W, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 27: clk_3125 cycles per bit, ≥1 (27 ≈ 115200 baud at 3.125 MHz).
- FIFO_DEPTH, 4: FIFO entries, a power of two ≥2; used only with UART_TX_FIFO_EN.

Ports:
- clk_3125  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block accepts the word this cycle.
- parity_mode  in  2  2'b00 none, 2'b01 even, 2'b10 odd, 2'b11 none (reserved).
- two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line.
- tx_done  out  1  one-cycle pulse after a frame's last stop bit.

## Operation
- Transfer: a word is accepted on a rising edge with tx_valid && tx_ready. tx_data, parity_mode and two_stop are captured together. Config changes mid-frame do not affect the current frame.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE/START.
  - PARITY is skipped when the mode is none.
  - STOP lasts 1 or 2 bit periods.
- Baud counter: runs 0..CLKS_PER_BIT-1 and resets on each bit boundary. A bit advances when the counter equals CLKS_PER_BIT-1.
- Bit counter: counts DATA bits 0..DATA_W-1; $clog2(DATA_W) bits wide, no wrap.
- Parity bit:
  - even: ^data, so the total count of ones is even.
  - odd: ~^data.
- Line levels: tx = 0 in START, data[i] in DATA, the parity bit in PARITY, 1 in STOP and IDLE. tx is registered.
- Frame length: (1 + DATA_W + P + S) × CLKS_PER_BIT cycles, where P ∈ {0,1} and S ∈ {1,2}.
- tx_ready without the FIFO: high in IDLE and during the final clock of the final stop bit. An acceptance there enters START directly, with no idle cycle between frames.
- tx_busy: high from the first START cycle through the final stop-bit cycle.
- tx_done: pulses exactly once per frame, in the cycle after the final stop-bit clock, including during back-to-back transfers.
- Reset, asynchronous:
  - tx = 1, tx_busy = 0, tx_done = 0, tx_ready = 1, FSM = IDLE, counters = 0.
  - An in-flight frame is abandoned and the line returns high at once.

## Timing
- Acceptance at edge k: tx falls at edge k (output valid from k+1 cycle onward).
- Start bit lasts CLKS_PER_BIT cycles.
- tx_done is high during the cycle starting at edge k + frame length.
- Sustained valid gives 100% line utilisation; successive tx_done pulses are exactly one frame length apart.
- tx_valid may drop without acceptance; the block samples it only when tx_ready is high.

## Configuration
- UART_TX_FIFO_EN defined:
  - A FIFO_DEPTH FIFO sits between the handshake and the shifter; tx_ready = !full.
  - The shifter pops when idle, or on the final stop clock if non-empty.
  - The first word after empty has one extra cycle of latency (accept at k → tx low from k+2).
  - Reset empties the FIFO.
- UART_TX_FIFO_EN undefined: no FIFO logic; tx_ready follows the Operation rule; FIFO_DEPTH is ignored.

## Structure
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state typedef tx_state_t;
  - a parity function.
- Sub-module uart_tx_fifo (synchronous, same clock/reset, push/pop/full/empty) is instantiated only under UART_TX_FIFO_EN.

## Test plan
- Single frame: CLKS_PER_BIT=4, DATA_W=8, 0xA5, even parity, one stop → tx levels 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; tx_done at cycle 44; tx_busy high for 44 cycles.
- Odd parity, two stops: data 0x00 → parity bit 1; frame 12 bits = 48 cycles; tx high after.
- Back-to-back: no parity, 0x55 then 0x0F with tx_valid held → no idle cycle between stop and start; tx_done pulses exactly 40 cycles apart.
- Reset mid-DATA (bit 3 of 0xA5): tx = 1 and tx_busy = 0 immediately. After release, 0x3C transmits correctly.
- DATA_W=5, CLKS_PER_BIT=1, parity none: 5'h1F → 0,1,1,1,1,1,1; 7-cycle frame.
- UART_TX_FIFO_EN, FIFO_DEPTH=4: push 6 words continuously → tx_ready falls once 4 words are queued. All 6 are transmitted in order; the FIFO is empty at the end.
